// File: rtl/display_scan_controller_if.sv
// ---------------------------------------------------------------------------
// display_scan_controller_if
// Groups the digit sources and the display drive lines of the scan controller.
//   master : the surrounding system -- drives the digit data and display
//            options, and observes the display drive lines.
//   slave  : the scan controller -- reads the digit data and display options,
//            and drives anode/segment/dp plus the status outputs.
// Signals:
//   clock_digits, stopwatch_digits : BCD nibbles, nibble i = digit i (0 rightmost)
//   mode_sel    : 0 = clock digits, 1 = stopwatch digits
//   lz_en       : leading-zero blanking enable
//   dp_mask     : 1 = light decimal point of digit i
//   anode       : active-low digit enables
//   segment     : active-low {g,f,e,d,c,b,a}
//   dp          : active-low decimal point
//   digit_index : digit currently being scanned
//   frame_start : one-cycle pulse when a new frame snapshot is taken
//   active_mode : mode_sel captured for the current frame
// ---------------------------------------------------------------------------
interface display_scan_controller_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] clock_digits;
    logic [4*NUM_DIGITS-1:0] stopwatch_digits;
    logic                    mode_sel;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   anode;
    logic [6:0]              segment;
    logic                    dp;
    logic [2:0]              digit_index;
    logic                    frame_start;
    logic                    active_mode;

    modport master (
        output clock_digits, stopwatch_digits, mode_sel, lz_en, dp_mask,
        input  anode, segment, dp, digit_index, frame_start, active_mode
    );

    modport slave (
        input  clock_digits, stopwatch_digits, mode_sel, lz_en, dp_mask,
        output anode, segment, dp, digit_index, frame_start, active_mode
    );
endinterface

// File: rtl/display_scan_controller.sv
// ---------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexed scan of a multi-digit seven-segment display. Each frame
// starts with a one-cycle LOAD that snapshots the selected digit source and
// display options, then every digit gets BLANK_TICKS cycles with all anodes
// off followed by TICKS_PER_DIGIT cycles with its own anode on.
// Ports:
//   i_clock : system clock, rising edge
//   i_reset : synchronous, active-high
//   bus     : display_scan_controller_if.slave (data in, display drive out)
// All display outputs are registered and computed from the next state, so
// anode/segment/dp move on the same edge as the state transition.
// ---------------------------------------------------------------------------
module display_scan_controller #(
    parameter int NUM_DIGITS      = 8,
    parameter int TICKS_PER_DIGIT = 1000,
    parameter int BLANK_TICKS     = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    display_scan_controller_if.slave      bus
);

    localparam int CNT_MAX = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BLANK,
        S_ON
    } state_t;

    state_t                  r_state, w_state_next;
    logic [CNT_W-1:0]        r_tick, w_tick_next;
    logic [2:0]              r_digit, w_digit_next;

    logic [4*NUM_DIGITS-1:0] r_snap_data;
    logic                    r_snap_lz;
    logic [NUM_DIGITS-1:0]   r_snap_dp;

    logic [NUM_DIGITS-1:0]   r_anode, w_anode_next;
    logic [6:0]              r_segment, w_segment_next;
    logic                    r_dp, w_dp_next;
    logic                    r_frame_start, w_frame_start_next;
    logic                    r_active_mode;

    logic                    w_load;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_nib_zero;
    logic [NUM_DIGITS-1:0]   w_lz_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;   // non-BCD nibble shows a dash
        endcase
        return seg;
    endfunction

    // Per-digit leading-zero blanking: digit i goes dark when it and every
    // more significant nibble of the snapshot are zero. Digit 0 always shows.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib[gi]      = r_snap_data[4*gi +: 4];
            assign w_nib_zero[gi] = (w_nib[gi] == 4'd0);
            if (gi == 0) begin : g_first
                assign w_lz_blank[gi] = 1'b0;
            end else begin : g_rest
                assign w_lz_blank[gi] = r_snap_lz && (&w_nib_zero[NUM_DIGITS-1:gi]);
            end
        end
    endgenerate

    // Next-state and next-output logic.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        w_digit_next = r_digit;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_LOAD;
                w_tick_next  = '0;
                w_digit_next = 3'd0;
            end
            S_LOAD: begin
                w_state_next = S_BLANK;
                w_tick_next  = '0;
                w_digit_next = 3'd0;
            end
            S_BLANK: begin
                if (r_tick == BLANK_LAST) begin
                    w_state_next = S_ON;
                    w_tick_next  = '0;
                end else begin
                    w_tick_next = r_tick + CNT_W'(1);
                end
            end
            S_ON: begin
                if (r_tick == ON_LAST) begin
                    w_tick_next = '0;
                    if (r_digit == LAST_DIGIT) begin
                        w_state_next = S_LOAD;
                        w_digit_next = 3'd0;
                    end else begin
                        w_state_next = S_BLANK;
                        w_digit_next = r_digit + 3'd1;
                    end
                end else begin
                    w_tick_next = r_tick + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tick_next  = '0;
                w_digit_next = 3'd0;
            end
        endcase

        w_load             = (w_state_next == S_LOAD);
        w_frame_start_next = w_load;
        w_anode_next       = '1;
        w_segment_next     = 7'h7F;
        w_dp_next          = 1'b1;

        // ON is never entered straight from LOAD, so the current snapshot
        // registers are already valid whenever the next state is ON.
        if (w_state_next == S_ON) begin
            w_dp_next = ~r_snap_dp[w_digit_next];
            if (!w_lz_blank[w_digit_next]) begin
                w_anode_next   = ~(NUM_DIGITS'(1) << w_digit_next);
                w_segment_next = seg_decode(w_nib[w_digit_next]);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_tick        <= '0;
            r_digit       <= 3'd0;
            r_snap_data   <= '0;
            r_snap_lz     <= 1'b0;
            r_snap_dp     <= '0;
            r_anode       <= '1;
            r_segment     <= 7'h7F;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
            r_active_mode <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_tick        <= w_tick_next;
            r_digit       <= w_digit_next;
            r_anode       <= w_anode_next;
            r_segment     <= w_segment_next;
            r_dp          <= w_dp_next;
            r_frame_start <= w_frame_start_next;
            if (w_load) begin
                r_active_mode <= bus.mode_sel;
                r_snap_data   <= bus.mode_sel ? bus.stopwatch_digits : bus.clock_digits;
                r_snap_lz     <= bus.lz_en;
                r_snap_dp     <= bus.dp_mask;
            end
        end
    end

    assign bus.anode       = r_anode;
    assign bus.segment     = r_segment;
    assign bus.dp          = r_dp;
    assign bus.digit_index = r_digit;
    assign bus.frame_start = r_frame_start;
    assign bus.active_mode = r_active_mode;

endmodule

// File: tb/tb_display_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_display_scan_controller
// Drives the scan controller with directed and random digit data, mode,
// blanking and decimal-point settings plus occasional resets. A reference
// model derives the expected outputs from the cycle count since reset using
// the frame arithmetic (LOAD, then per digit BLANK_TICKS blank + TICKS_PER_DIGIT
// on), and the per-frame snapshot of the inputs.
// ---------------------------------------------------------------------------
module tb_display_scan_controller;

    localparam int N = 8;
    localparam int T = 4;
    localparam int B = 2;
    localparam int F = 1 + N * (B + T);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan_controller_if #(.NUM_DIGITS(N)) bus ();

    display_scan_controller #(
        .NUM_DIGITS      (N),
        .TICKS_PER_DIGIT (T),
        .BLANK_TICKS     (B)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [6:0]  seg_tab [16];
    int          k;          // rising edges since reset released
    logic [31:0] m_data;
    logic        m_lz;
    logic        m_mode;
    logic [7:0]  m_mask;
    int          m_digit;
    bit          m_on;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic step();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fs;
        int         e_idx;
        int         p;
        int         q;
        logic [3:0] nib;
        bit         blank;
        @(negedge clk);
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_idx = 0;
        m_on = 1'b0; m_digit = -1;
        if (rst) begin
            k = 0;
            m_mode = 1'b0;
        end else begin
            k++;
            p = (k - 1) % F;
            if (p == 0) begin
                m_mode = bus.mode_sel;
                m_data = bus.mode_sel ? bus.stopwatch_digits : bus.clock_digits;
                m_lz   = bus.lz_en;
                m_mask = bus.dp_mask;
                e_fs   = 1'b1;
                $display("frame t=%0t mode=%0d data=%h lz=%0d dp_mask=%h",
                         $time, m_mode, m_data, m_lz, m_mask);
            end else begin
                q       = p - 1;
                e_idx   = q / (B + T);
                m_digit = e_idx;
                if ((q % (B + T)) >= B) begin
                    m_on  = 1'b1;
                    e_dp  = ~m_mask[e_idx];
                    nib   = m_data[4*e_idx +: 4];
                    blank = m_lz && (e_idx != 0) && ((m_data >> (4 * e_idx)) == 32'd0);
                    if (!blank) begin
                        e_an  = ~(8'd1 << e_idx);
                        e_seg = seg_tab[nib];
                    end
                end
            end
        end
        chk("anode",       32'(bus.anode),       32'(e_an));
        chk("segment",     32'(bus.segment),     32'(e_seg));
        chk("dp",          32'(bus.dp),          32'(e_dp));
        chk("digit_index", 32'(bus.digit_index), 32'(e_idx));
        chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
        chk("active_mode", 32'(bus.active_mode), 32'(m_mode));
        chk("one_anode",   32'($countones(~bus.anode) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model is inside the requested digit phase (bounded).
    task automatic wait_digit(input int d, input bit on);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            if (m_digit == d && m_on == on) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("wait_digit_timeout", 32'(found), 32'd1);
    endtask

    function automatic logic [31:0] rand_digits();
        logic [31:0] v;
        int          z;
        v = $urandom;
        z = $urandom_range(0, 8);
        for (int i = 0; i < z; i++) v[4*(7-i) +: 4] = 4'd0;
        return v;
    endfunction

    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
        k = 0; m_data = '0; m_lz = 1'b0; m_mode = 1'b0; m_mask = '0;
        m_digit = -1; m_on = 1'b0;

        bus.clock_digits     = 32'h12345678;
        bus.stopwatch_digits = 32'h0;
        bus.mode_sel         = 1'b0;
        bus.lz_en            = 1'b0;
        bus.dp_mask          = 8'h00;

        // Reset and release, two full frames of clock digits.
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(2 * F);

        // Mode change mid-frame only takes effect at the next snapshot.
        wait_digit(3, 1'b1);
        bus.mode_sel         = 1'b1;
        bus.stopwatch_digits = 32'h87654321;
        run(2 * F);

        // Leading-zero blanking on stopwatch data, then all zeros.
        bus.stopwatch_digits = 32'h00000305;
        bus.lz_en            = 1'b1;
        run(2 * F);
        bus.stopwatch_digits = 32'h0;
        run(2 * F);

        // Dash for a non-BCD nibble, decimal point on digit 2 only.
        bus.mode_sel     = 1'b0;
        bus.lz_en        = 1'b0;
        bus.clock_digits = 32'h9876C210;
        bus.dp_mask      = 8'h04;
        run(2 * F);

        // Reset in the middle of digit 5's on-window.
        wait_digit(5, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(F + 4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 99) < 3) bus.clock_digits     = rand_digits();
            if ($urandom_range(0, 99) < 3) bus.stopwatch_digits = rand_digits();
            if ($urandom_range(0, 99) < 2) bus.mode_sel         = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 2) bus.lz_en            = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 2) bus.dp_mask          = 8'($urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        run(F);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
